// File: rtl/fifo2sdram_wr_ctrl.sv
// FIFO-to-SDRAM write sequencer: reads one word at a time from a standard
// (non-FWFT) FIFO and presents it as a valid/ready write beat with burst framing.
module fifo2sdram_wr_ctrl #(
  parameter int                DATA_W    = 16,
  parameter int                ADDR_W    = 24,
  parameter int                BURST_LEN = 8,
  parameter logic [ADDR_W-1:0] ADDR_BASE = '0,
  parameter logic [ADDR_W-1:0] ADDR_TOP  = '1,
  parameter bit                WRAP_EN   = 1'b1
) (
  input  logic              sdram_clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              addr_clr,
  input  logic [DATA_W-1:0] fifo_rdata,
  input  logic              fifo_rempty,
  output logic              fifo_ren,
  output logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic              wr_last,
  output logic              frame_done,
  output logic              halted,
  output logic [31:0]       word_cnt
);

  localparam int                BEAT_W   = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(BURST_LEN - 1);

  typedef enum logic [2:0] {IDLE, REQ, CAP, SEND, HALT} state_t;

  state_t            state;
  logic [BEAT_W-1:0] beat_cnt;

  logic              at_top;
  logic              accept;
  logic              can_read;
  logic [ADDR_W-1:0] addr_next;
  logic [BEAT_W-1:0] beat_next;

  assign at_top    = (wr_addr == ADDR_TOP);
  assign accept    = wr_valid && wr_ready;
  assign can_read  = enable && !fifo_rempty;
  assign beat_next = (beat_cnt == BEAT_MAX) ? '0 : beat_cnt + 1'b1;

  // Without wrap the address parks on ADDR_TOP; HALT keeps it from being reused.
  always_comb begin
    addr_next = wr_addr + 1'b1;
    if (at_top) addr_next = WRAP_EN ? ADDR_BASE : wr_addr;
  end

  always_ff @(posedge sdram_clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      fifo_ren   <= 1'b0;
      wr_data    <= '0;
      wr_addr    <= ADDR_BASE;
      wr_valid   <= 1'b0;
      wr_last    <= 1'b0;
      frame_done <= 1'b0;
      halted     <= 1'b0;
      beat_cnt   <= '0;
      word_cnt   <= '0;
    end else begin
      fifo_ren   <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (addr_clr) begin
            wr_addr  <= ADDR_BASE;
            beat_cnt <= '0;
            word_cnt <= '0;
          end else if (!enable) begin
            beat_cnt <= '0;
          end
          if (can_read) begin
            state    <= REQ;
            fifo_ren <= 1'b1;
          end
        end
        REQ: state <= CAP;
        CAP: begin
          // FIFO data is valid in the cycle after the read strobe.
          wr_data  <= fifo_rdata;
          wr_valid <= 1'b1;
          wr_last  <= (beat_cnt == BEAT_MAX);
          state    <= SEND;
        end
        SEND: begin
          if (accept) begin
            wr_valid   <= 1'b0;
            wr_last    <= 1'b0;
            word_cnt   <= word_cnt + 32'd1;
            beat_cnt   <= beat_next;
            wr_addr    <= addr_next;
            frame_done <= at_top;
            if (at_top && !WRAP_EN) begin
              state  <= HALT;
              halted <= 1'b1;
            end else if (can_read) begin
              state    <= REQ;
              fifo_ren <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        HALT: begin
          if (addr_clr) begin
            state    <= IDLE;
            halted   <= 1'b0;
            wr_addr  <= ADDR_BASE;
            beat_cnt <= '0;
            word_cnt <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
